psum_relu_buffer: RTL and testbench

- Downstream stage of the per-column three-row partial-sum adder in the weight-stationary PE array.
- Consumes its signed 10-bit sum Q once per cycle, accumulates KCOLS consecutive sums (kernel columns) into one output-pixel value, applies ReLU and unsigned saturation, and queues results in a small FIFO.
- The FIFO drains through a valid/ready interface toward the feature-map writeback.

---
 rtl/ws_pkg.sv | 31 +++
 rtl/ws_sync_fifo.sv | 45 ++++
 rtl/psum_relu_buffer.sv | 88 ++++++++
 tb/tb_psum_relu_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// Shared constants and output-stage helpers for the weight-stationary PE array.
package ws_pkg;

   localparam int unsigned PSUM_W = 10;
   localparam int unsigned OUT_W  = 8;
   localparam int unsigned KCOLS  = 3;
   localparam int unsigned ACC_W  = PSUM_W + $clog2(KCOLS) + 1;

   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

   typedef struct packed {
      logic             sat;
      logic [OUT_W-1:0] val;
   } relu_t;

   // ReLU followed by unsigned saturation; sat marks a high-side clamp only
   function automatic relu_t relu_sat(input logic signed [ACC_W-1:0] sum);
      relu_t r;
      r = '0;
      if (sum[ACC_W-1]) begin
         r.val = '0;
      end else if (sum > OUT_MAX) begin
         r.sat = 1'b1;
         r.val = '1;
      end else begin
         r.val = sum[OUT_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/ws_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; shows zero on rdata when empty.
module ws_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             sys_clk,
   input  logic             CLR,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge sys_clk or posedge CLR) begin
      if (CLR) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: rdata is masked while empty
   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/psum_relu_buffer.sv
// Accumulates KCOLS partial sums per output pixel, applies ReLU/saturation,
// and queues activations toward feature-map writeback.
module psum_relu_buffer
   import ws_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     sys_clk,
   input  logic                     CLR,
   input  logic                     sync_clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [PSUM_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic                     sat_flag,
   output logic [15:0]              grp_cnt
);

   localparam int unsigned BEAT_W = (KCOLS > 1) ? $clog2(KCOLS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(KCOLS - 1);

   logic [BEAT_W-1:0]       beat_cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] in_ext;
   logic signed [ACC_W-1:0] sum;
   logic                    last_beat;
   logic                    accept;
   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   relu_t                   res;

   assign in_ext    = {{(ACC_W-PSUM_W){in_data[PSUM_W-1]}}, in_data};
   assign sum       = acc + in_ext;
   assign res       = relu_sat(sum);
   assign last_beat = (beat_cnt == LAST_BEAT);

   // Only the completing beat can be stalled, and only by a full FIFO
   assign in_ready  = ~last_beat | ~fifo_full;
   assign accept    = in_valid & in_ready & ~sync_clr;
   assign push      = accept & last_beat;
   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge sys_clk or posedge CLR) begin
      if (CLR) begin
         beat_cnt <= '0;
         acc      <= '0;
         sat_flag <= 1'b0;
         grp_cnt  <= '0;
      end else begin
         if (sync_clr) begin
            beat_cnt <= '0;
            acc      <= '0;
         end else if (accept) begin
            if (last_beat) begin
               beat_cnt <= '0;
               acc      <= '0;
            end else begin
               beat_cnt <= beat_cnt + BEAT_W'(1);
               acc      <= (beat_cnt == '0) ? in_ext : sum;
            end
         end
         if (push) begin
            grp_cnt <= grp_cnt + 16'd1;
            if (res.sat) sat_flag <= 1'b1;
         end
      end
   end

   ws_sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .sys_clk (sys_clk),
      .CLR     (CLR),
      .push    (push),
      .pop     (pop),
      .wdata   (res.val),
      .rdata   (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_psum_relu_buffer.sv
// Directed bench for psum_relu_buffer: per-cycle vector table plus corner sequences.
module tb_psum_relu_buffer;

   logic              sys_clk = 1'b0;
   logic              CLR;
   logic              sync_clr;
   logic              in_valid;
   logic              in_ready;
   logic signed [9:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic              sat_flag;
   logic [15:0]       grp_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic              iv;
      logic signed [9:0] d;
      logic              ordy;
      logic              sclr;
      logic              e_ir;
      logic              e_ov;
      logic [7:0]        e_od;
      logic              e_sat;
      logic [15:0]       e_grp;
   } vec_t;

   vec_t vecs[$];

   psum_relu_buffer #(.DEPTH(4)) dut (
      .sys_clk   (sys_clk),
      .CLR       (CLR),
      .sync_clr  (sync_clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_flag  (sat_flag),
      .grp_cnt   (grp_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic vec_t mk(input logic iv, input int d, input logic ordy, input logic sclr,
                               input logic e_ir, input logic e_ov, input int e_od,
                               input logic e_sat, input int e_grp);
      vec_t v;
      v.iv = iv; v.d = 10'(d); v.ordy = ordy; v.sclr = sclr;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = 8'(e_od); v.e_sat = e_sat; v.e_grp = 16'(e_grp);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic ir, input logic ov, input int od,
                            input logic sat, input int grp);
      chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      chk({tag, ".out_data"},  32'(out_data),  32'(od));
      chk({tag, ".sat_flag"},  32'(sat_flag),  32'(sat));
      chk({tag, ".grp_cnt"},   32'(grp_cnt),   32'(grp));
   endtask

   task automatic do_reset();
      CLR = 1'b1; sync_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      CLR = 1'b0;
   endtask

   // Present one beat from a negedge and hold it until accepted (bounded)
   task automatic send_beat(input int d);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = 10'(d);
      for (int i = 0; i < 50; i++) begin
         #1;
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge sys_clk);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_beat_timeout: in_ready stuck at 0 for beat %0d", d);
      end
      @(negedge sys_clk);
      in_valid = 1'b0;
   endtask

   task automatic send_group(input int a, input int b, input int c);
      send_beat(a);
      send_beat(b);
      send_beat(c);
   endtask

   task automatic drain(input string tag, input int exp);
      out_ready = 1'b1;
      #1;
      chk({tag, ".ov"}, 32'(out_valid), 32'd1);
      chk({tag, ".od"}, 32'(out_data), 32'(exp));
      @(negedge sys_clk);
   endtask

   initial begin
      // Basic group then clamp groups, one vector per cycle
      vecs.push_back(mk(1,  100, 1, 0, 1, 0,   0, 0, 0));
      vecs.push_back(mk(1,   50, 1, 0, 1, 0,   0, 0, 0));
      vecs.push_back(mk(1,  -20, 1, 0, 1, 0,   0, 0, 0));
      vecs.push_back(mk(0,    0, 1, 0, 1, 1, 130, 0, 1));
      vecs.push_back(mk(0,    0, 1, 0, 1, 0,   0, 0, 1));
      vecs.push_back(mk(1,  200, 0, 0, 1, 0,   0, 0, 1));
      vecs.push_back(mk(1,  100, 0, 0, 1, 0,   0, 0, 1));
      vecs.push_back(mk(1,   50, 0, 0, 1, 0,   0, 0, 1));
      vecs.push_back(mk(1, -300, 0, 0, 1, 1, 255, 1, 2));
      vecs.push_back(mk(1,  100, 0, 0, 1, 1, 255, 1, 2));
      vecs.push_back(mk(1,   50, 0, 0, 1, 1, 255, 1, 2));
      vecs.push_back(mk(0,    0, 1, 0, 1, 1, 255, 1, 3));
      vecs.push_back(mk(0,    0, 1, 0, 1, 1,   0, 1, 3));
      vecs.push_back(mk(0,    0, 0, 0, 1, 0,   0, 1, 3));

      CLR = 1'b1; sync_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3;
      chk_state("reset", 1'b1, 1'b0, 0, 1'b0, 0);
      do_reset();

      foreach (vecs[i]) begin
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].d;
         out_ready = vecs[i].ordy;
         sync_clr  = vecs[i].sclr;
         #1;
         chk_state($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, 32'(vecs[i].e_od),
                   vecs[i].e_sat, 32'(vecs[i].e_grp));
         @(negedge sys_clk);
      end
      in_valid = 1'b0;

      // Backpressure: FIFO full stalls the completing beat until one pop
      do_reset();
      for (int k = 1; k <= 4; k++) send_group(1, 1, k);
      send_beat(1);
      send_beat(1);
      in_valid = 1'b1; in_data = 10'sd5;
      #1;
      chk_state("bp.stall", 1'b0, 1'b1, 3, 1'b0, 4);
      @(negedge sys_clk);
      #1;
      chk("bp.hold_ir", 32'(in_ready), 32'd0);
      chk("bp.hold_od", 32'(out_data), 32'd3);
      out_ready = 1'b1;
      #1;
      chk("bp.no_comb_ir", 32'(in_ready), 32'd0);
      @(negedge sys_clk);
      out_ready = 1'b0;
      #1;
      chk_state("bp.freed", 1'b1, 1'b1, 4, 1'b0, 4);
      @(negedge sys_clk);
      in_valid = 1'b0;
      #1;
      chk_state("bp.pushed", 1'b1, 1'b1, 4, 1'b0, 5);
      for (int k = 4; k <= 7; k++) drain($sformatf("bp.drain%0d", k), k);
      out_ready = 1'b0;
      #1;
      chk("bp.empty", 32'(out_valid), 32'd0);
      @(negedge sys_clk);

      // Push and pop on the same edge around a full FIFO
      do_reset();
      for (int k = 1; k <= 4; k++) send_group(1, 1, k);
      send_beat(1);
      send_beat(1);
      in_valid = 1'b1; in_data = 10'sd5; out_ready = 1'b1;
      #1;
      chk_state("pp.full", 1'b0, 1'b1, 3, 1'b0, 4);
      @(negedge sys_clk);
      #1;
      chk_state("pp.both", 1'b1, 1'b1, 4, 1'b0, 4);
      @(negedge sys_clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk_state("pp.after", 1'b1, 1'b1, 5, 1'b0, 5);
      @(negedge sys_clk);
      for (int k = 5; k <= 7; k++) drain($sformatf("pp.drain%0d", k), k);
      out_ready = 1'b0;
      #1;
      chk("pp.empty", 32'(out_valid), 32'd0);
      @(negedge sys_clk);

      // sync_clr drops the partial group and the beat presented with it
      do_reset();
      out_ready = 1'b1;
      send_beat(10);
      send_beat(20);
      in_valid = 1'b1; in_data = 10'sd30; sync_clr = 1'b1;
      #1;
      chk("sc.in_ready", 32'(in_ready), 32'd1);
      @(negedge sys_clk);
      sync_clr = 1'b0; in_valid = 1'b0;
      send_group(1, 2, 3);
      #1;
      chk_state("sc.result", 1'b1, 1'b1, 6, 1'b0, 1);
      @(negedge sys_clk);
      #1;
      chk_state("sc.drained", 1'b1, 1'b0, 0, 1'b0, 1);
      @(negedge sys_clk);

      // Asynchronous CLR between edges with queued data and a partial group
      do_reset();
      send_group(1, 1, 1);
      send_group(200, 200, 200);
      send_beat(7);
      #1;
      chk_state("ar.before", 1'b1, 1'b1, 3, 1'b1, 2);
      #1;
      CLR = 1'b1;
      #1;
      chk_state("ar.during", 1'b1, 1'b0, 0, 1'b0, 0);
      #1;
      CLR = 1'b0;
      @(negedge sys_clk);
      send_group(5, 5, 5);
      #1;
      chk_state("ar.after", 1'b1, 1'b1, 15, 1'b0, 1);
      out_ready = 1'b1;
      @(negedge sys_clk);
      // Exactly 255 must pass without setting the saturation flag
      send_group(-512, 511, 256);
      #1;
      chk_state("edge255", 1'b1, 1'b1, 255, 1'b0, 2);
      @(negedge sys_clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
